// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and default geometry for the nibble-serial add/subtract engine.
package nibble_serial_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Counter width for n slices; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_SLICE  = 4;
   localparam int unsigned DEF_NSLICE = DEF_WIDTH / DEF_SLICE;
   localparam int unsigned DEF_IDX_W  = idx_width(DEF_NSLICE);

endpackage

// File: rtl/nibble_serial_addsub_slice.sv
// Combinational SLICE-bit ripple adder (the shared addsub slice), built from
// per-bit full-adder equations; also exposes the carry into its MSB.
module nibble_serial_addsub_slice
   import nibble_serial_addsub_pkg::*;
#(
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [SLICE:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < SLICE; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = c[SLICE];
   assign c_msb = c[SLICE-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract engine that walks one shared SLICE-bit adder across
// the operands, low slice first, with valid/ready on both sides.
module nibble_serial_addsub
   import nibble_serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IDX_W  = idx_width(NSLICE);
   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NSLICE - 1);

   if ((WIDTH % SLICE) != 0) begin : g_bad_geometry
      $error("nibble_serial_addsub: WIDTH must be a multiple of SLICE");
   end

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   k_q, k_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic               sub_q, sub_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [SLICE-1:0]   sl_a, sl_b, sl_s;
   logic               sl_cout, sl_cmsb;
   logic               last_slice;
   logic               ovf_calc;
   logic               accept;

   assign sl_a = a_q[k_q*SLICE +: SLICE];
   assign sl_b = b_q[k_q*SLICE +: SLICE];

   nibble_serial_addsub_slice #(
      .SLICE (SLICE)
   ) u_addsub_slice (
      .a     (sl_a),
      .b     (sl_b),
      .cin   (carry_q),
      .s     (sl_s),
      .cout  (sl_cout),
      .c_msb (sl_cmsb)
   );

   assign last_slice = (k_q == LAST_K);
   // Only meaningful on the last slice, where sl_s holds the result MSB.
   assign ovf_calc   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sl_s[SLICE-1] != a_q[WIDTH-1]);

   // DONE hands its ready straight through so a new operand set can be
   // taken on the same edge the result leaves.
   assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      sub_d       = sub_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               a_d         = a;
               b_d         = sub ? ~b : b;
               carry_d     = sub ^ cin;
               sub_d       = sub;
               k_d         = '0;
               sum_d       = '0;
               state_d     = ST_RUN;
               busy_d      = 1'b1;
               out_valid_d = 1'b0;
            end else if (state_q == ST_DONE && out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end

         ST_RUN: begin
            sum_d[k_q*SLICE +: SLICE] = sl_s;
            carry_d = sl_cout;
            k_d     = k_q + IDX_W'(1);
            if (last_slice) begin
               k_d         = '0;
               cout_d      = sub_q ? ~sl_cout : sl_cout;
               ovf_d       = ovf_calc;
               state_d     = ST_DONE;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         sub_q       <= sub_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Sign-rule overflow must agree with the carry-in/carry-out view of the MSB.
   always_ff @(posedge clk) begin
      if (rst_n && state_q == ST_RUN && last_slice)
         assert (ovf_calc == (sl_cmsb ^ sl_cout));
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub: expected results come from a
// full-width arithmetic model and are queued at issue time.
module tb_nibble_serial_addsub;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
   } vec_t;

   res_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   nibble_serial_addsub #(.WIDTH(W), .SLICE(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic s);
      res_t       r;
      logic [W:0] t;
      if (!s) begin
         t     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
         r.ovf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      end else begin
         t     = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
         r.ovf = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
      end
      r.sum  = t[W-1:0];
      r.cout = t[W];
      return r;
   endfunction

   // Presents an operand set from posedge+1 until it is taken; returns at
   // posedge+1 of the accepting edge. waited = edges spent before accept.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, output bit ok, output int waited);
      a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
      ok = 1'b0; waited = 0;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
         waited++;
      end
      in_valid = 1'b0;
      if (ok) sb.push_back(model(x, y, ci, s));
   endtask

   task automatic wait_out(output int cyc, output bit to);
      cyc = 0; to = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({in_ready, out_valid, busy, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b ovf=%b required 1 0 0 0000 0 0",
                  in_ready, out_valid, busy, sum, cout, ovf);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      vec_t vt[4];
      bit ok; int waited, cyc; bit to; res_t e;
      vt[0] = '{a:16'h1234, b:16'h2345, cin:1'b0, sub:1'b0};
      vt[1] = '{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0};
      vt[2] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, sub:1'b0};
      vt[3] = '{a:16'($urandom), b:16'($urandom), cin:1'b1, sub:1'b0};
      for (int i = 0; i < 4; i++) begin
         issue(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, ok, waited);
         n_checks++;
         if (!ok || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_run_state[%0d]: accepted=%b busy=%b in_ready=%b out_valid=%b required 1 1 0 0",
                     i, ok, busy, in_ready, out_valid);
         end
         if (!ok) continue;
         wait_out(cyc, to);
         n_checks++;
         if (to || cyc != 4) begin
            n_fail++;
            $display("FAIL add_latency[%0d]: cycles=%0d timeout=%b required 4", i, cyc, to);
         end
         e = sb.pop_front();
         n_checks++;
         if ({sum, cout, ovf} !== e) begin
            n_fail++;
            $display("FAIL add_result[%0d]: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     i, sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
         take_result();
      end
   endtask

   task automatic test_sub();
      vec_t vt[4];
      bit ok; int waited, cyc; bit to; res_t e;
      vt[0] = '{a:16'h0005, b:16'h0007, cin:1'b0, sub:1'b1};
      vt[1] = '{a:16'h8000, b:16'h0001, cin:1'b0, sub:1'b1};
      vt[2] = '{a:16'h0010, b:16'h0001, cin:1'b1, sub:1'b1};
      vt[3] = '{a:16'($urandom), b:16'($urandom), cin:1'b1, sub:1'b1};
      for (int i = 0; i < 4; i++) begin
         issue(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, ok, waited);
         wait_out(cyc, to);
         n_checks++;
         if (!ok || to || cyc != 4) begin
            n_fail++;
            $display("FAIL sub_latency[%0d]: accepted=%b cycles=%0d timeout=%b required 4", i, ok, cyc, to);
         end
         if (!ok) continue;
         e = sb.pop_front();
         n_checks++;
         if ({sum, cout, ovf} !== e) begin
            n_fail++;
            $display("FAIL sub_result[%0d]: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     i, sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
         take_result();
      end
   endtask

   task automatic test_backpressure();
      bit ok; int waited, cyc; bit to; res_t e;
      issue(16'h7FF0, 16'h0020, 1'b0, 1'b0, ok, waited);
      wait_out(cyc, to);
      n_checks++;
      if (!ok || to) begin
         n_fail++;
         $display("FAIL bp_result_arrival: accepted=%b timeout=%b required 1 0", ok, to);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, cout, ovf} !== e) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                     i, out_valid, in_ready, sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {sum, cout, ovf} !== e) begin
         n_fail++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b sum=%h required 0 1 %h", out_valid, in_ready, sum, e.sum);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_single_transfer: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int waited, cyc; bit to; res_t e;
      issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, ok, waited);
      wait_out(cyc, to);
      if (ok && !to) begin
         e = sb.pop_front();
         n_checks++;
         if ({sum, cout, ovf} !== e) begin
            n_fail++;
            $display("FAIL b2b_first: sum=%h cout=%b ovf=%b required %h %b %b", sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
      end
      out_ready = 1'b1;
      issue(16'h4000, 16'h4000, 1'b0, 1'b0, ok, waited);
      out_ready = 1'b0;
      n_checks++;
      if (!ok || waited != 0 || busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_same_edge: accepted=%b waited=%0d busy=%b out_valid=%b required 1 0 1 0",
                  ok, waited, busy, out_valid);
      end
      wait_out(cyc, to);
      n_checks++;
      if (!ok || to || cyc != 4) begin
         n_fail++;
         $display("FAIL b2b_latency: cycles=%0d timeout=%b required 4", cyc, to);
      end
      if (ok) begin
         e = sb.pop_front();
         n_checks++;
         if ({sum, cout, ovf} !== e) begin
            n_fail++;
            $display("FAIL b2b_second: sum=%h cout=%b ovf=%b required %h %b %b", sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
      end
      take_result();
   endtask

   task automatic test_reset_mid();
      bit ok; int waited, cyc; bit to; res_t e;
      issue(16'h1111, 16'h2222, 1'b0, 1'b0, ok, waited);
      if (ok) void'(sb.pop_back());
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, sum, busy, in_ready, cout, ovf} !== {1'b0, {W{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid: out_valid=%b sum=%h busy=%b in_ready=%b cout=%b ovf=%b required 0 0000 0 1 0 0",
                  out_valid, sum, busy, in_ready, cout, ovf);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(16'h0001, 16'h0001, 1'b0, 1'b0, ok, waited);
      wait_out(cyc, to);
      n_checks++;
      if (!ok || to || cyc != 4) begin
         n_fail++;
         $display("FAIL reset_mid_latency: accepted=%b cycles=%0d timeout=%b required 4", ok, cyc, to);
      end
      if (ok) begin
         e = sb.pop_front();
         n_checks++;
         if ({sum, cout, ovf} !== e || sum !== 16'h0002) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: sum=%h cout=%b ovf=%b required %h %b %b", sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
      end
      take_result();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
